// File: rtl/multi_paddle_pkg.sv
// Shared types and helpers for the multi-paddle controller.
// Coordinate widths, button/edge bit indices, saturation and clamp.
package multi_paddle_pkg;

  localparam int COORD_W  = 13;
  localparam int SCOORD_W = 14;

  localparam int DIR_U = 3;
  localparam int DIR_D = 2;
  localparam int DIR_L = 1;
  localparam int DIR_R = 0;

  localparam int EDGE_TOP   = 3;
  localparam int EDGE_BOT   = 2;
  localparam int EDGE_LEFT  = 1;
  localparam int EDGE_RIGHT = 0;

  typedef logic [COORD_W-1:0]         coord_t;
  typedef logic signed [SCOORD_W-1:0] scoord_t;

  typedef struct packed {
    coord_t pos;
    logic   lo;
    logic   hi;
  } clamp_t;

  // One +/-1 step, held when both or neither pressed,
  // limited to [-lim, +lim].
  function automatic scoord_t sat_step(
    input scoord_t d,
    input logic    inc,
    input logic    dec,
    input int      lim
  );
    scoord_t n;
    scoord_t l;
    l = scoord_t'(lim);
    n = d;
    if (inc && !dec)
      n = d + scoord_t'(1);
    else if (dec && !inc)
      n = d - scoord_t'(1);
    if (n > l)
      n = l;
    else if (n < -l)
      n = -l;
    return n;
  endfunction

  // Keep the paddle body fully on screen along one axis.
  function automatic clamp_t clamp(
    input coord_t  pos,
    input scoord_t d,
    input int      lo_off,
    input int      hi_off,
    input int      span
  );
    scoord_t s;
    scoord_t t;
    scoord_t b;
    clamp_t  r;
    s     = scoord_t'({1'b0, pos}) + d;
    t     = s - scoord_t'(lo_off);
    b     = s + scoord_t'(hi_off);
    r.pos = s[COORD_W-1:0];
    r.lo  = 1'b0;
    r.hi  = 1'b0;
    if (t < 0) begin
      r.pos = coord_t'(lo_off);
      r.lo  = 1'b1;
    end else if (b >= scoord_t'(span)) begin
      r.pos = coord_t'(span - 1 - hi_off);
      r.hi  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_paddle_ctrl_channel.sv
// One paddle: displacement accumulators, clamp on commit,
// edge-hit flags.
module paddle_channel
  import multi_paddle_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int HEIGHT    = 50,
  parameter int COLS      = 640,
  parameter int ROWS      = 480,
  parameter int MAX_STEP  = 8,
  parameter int VERT_ONLY = 0,
  parameter int INIT_ROW  = 240,
  parameter int INIT_COL  = 160
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample,
  input  logic         commit,
  input  logic [3:0]   move,
  output coord_t       pos_row,
  output coord_t       pos_col,
  output logic [3:0]   at_edge
);

  localparam int  ROW_LO = HEIGHT >> 1;
  localparam int  ROW_HI = (HEIGHT - 1) >> 1;
  localparam int  COL_LO = WIDTH >> 1;
  localparam int  COL_HI = (WIDTH - 1) >> 1;
  localparam logic H_EN  = (VERT_ONLY == 0);

  scoord_t    dv;
  scoord_t    dh;
  scoord_t    dv_nx;
  scoord_t    dh_nx;
  clamp_t     rc;
  clamp_t     cc;
  logic [3:0] edge_nx;

  // Next displacement on a sample, and clamped commit values.
  always_comb begin
    dv_nx = sat_step(dv, move[DIR_D], move[DIR_U], MAX_STEP);
    dh_nx = sat_step(dh, H_EN & move[DIR_R],
                     H_EN & move[DIR_L], MAX_STEP);
    rc = clamp(pos_row, dv, ROW_LO, ROW_HI, ROWS);
    cc = clamp(pos_col, dh, COL_LO, COL_HI, COLS);
    edge_nx             = '0;
    edge_nx[EDGE_TOP]   = rc.lo;
    edge_nx[EDGE_BOT]   = rc.hi;
    edge_nx[EDGE_LEFT]  = cc.lo;
    edge_nx[EDGE_RIGHT] = cc.hi;
  end

  // Accumulate between frames, commit and clear on frame edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_row <= coord_t'(INIT_ROW);
      pos_col <= coord_t'(INIT_COL);
      dv      <= '0;
      dh      <= '0;
      at_edge <= '0;
    end else if (commit) begin
      pos_row <= rc.pos;
      pos_col <= cc.pos;
      dv      <= '0;
      dh      <= '0;
      at_edge <= edge_nx;
    end else if (sample) begin
      dv <= dv_nx;
      dh <= dh_nx;
    end
  end

endmodule

// File: rtl/multi_paddle_ctrl.sv
// Multi-paddle position controller: shared sample divider,
// per-channel paddles, commit strobe.
module multi_paddle_ctrl
  import multi_paddle_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int WIDTH       = 20,
  parameter int HEIGHT      = 50,
  parameter int COLS        = 640,
  parameter int ROWS        = 480,
  parameter int SAMPLE_DIV  = 160000,
  parameter int MAX_STEP    = 8,
  parameter int VERT_ONLY   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic                           new_frame,
  input  logic [4*NUM_PADDLES-1:0]       move,
  output logic [COORD_W*NUM_PADDLES-1:0] pos_row,
  output logic [COORD_W*NUM_PADDLES-1:0] pos_col,
  output logic [COORD_W-1:0]             size_h,
  output logic [COORD_W-1:0]             size_w,
  output logic [4*NUM_PADDLES-1:0]       at_edge,
  output logic                           commit_valid
);

  localparam int CNT_W   = $clog2(SAMPLE_DIV + 1);
  localparam int COL_SEP = COLS / (2 * NUM_PADDLES);

  logic [CNT_W-1:0] cnt;
  logic             cnt_top;
  logic             tick;

  assign size_h  = COORD_W'(HEIGHT);
  assign size_w  = COORD_W'(WIDTH);
  assign cnt_top = (cnt == CNT_W'(SAMPLE_DIV));
  assign tick    = cnt_top & ~new_frame;

  // Sample divider, restarted by every frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= CNT_W'(1);
    else if (new_frame || cnt_top)
      cnt <= CNT_W'(1);
    else
      cnt <= cnt + CNT_W'(1);
  end

  // Strobe the cycle after positions were committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      commit_valid <= 1'b0;
    else
      commit_valid <= new_frame;
  end

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
    paddle_channel #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .COLS      (COLS),
      .ROWS      (ROWS),
      .MAX_STEP  (MAX_STEP),
      .VERT_ONLY (VERT_ONLY),
      .INIT_ROW  (ROWS / 2),
      .INIT_COL  (COL_SEP * (2 * i + 1))
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .sample  (tick & active),
      .commit  (new_frame),
      .move    (move[4*i +: 4]),
      .pos_row (pos_row[COORD_W*i +: COORD_W]),
      .pos_col (pos_col[COORD_W*i +: COORD_W]),
      .at_edge (at_edge[4*i +: 4])
    );
  end

endmodule

// File: tb/tb_multi_paddle_ctrl.sv
// Bench for multi_paddle_ctrl: free and vertical-only instances
// driven in parallel against a frame-level reference model.
module tb_multi_paddle_ctrl;

  localparam int NP = 2;
  localparam int W  = 20;
  localparam int H  = 50;
  localparam int C  = 640;
  localparam int R  = 480;
  localparam int SD = 4;
  localparam int MS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic        new_frame;
  logic [7:0]  move;

  logic [25:0] row_a, col_a, row_b, col_b;
  logic [12:0] sh_a, sw_a, sh_b, sw_b;
  logic [7:0]  ed_a, ed_b;
  logic        cv_a, cv_b;

  int checks = 0;
  int errors = 0;

  int         mrow [2][2];
  int         mcol [2][2];
  int         mdv  [2][2];
  int         mdh  [2][2];
  logic [3:0] med  [2][2];
  logic       mcv;
  int         mc;

  multi_paddle_ctrl #(
    .NUM_PADDLES (NP), .SAMPLE_DIV (SD), .VERT_ONLY (0)
  ) u_free (
    .clk (clk), .reset (reset), .active (active),
    .new_frame (new_frame), .move (move),
    .pos_row (row_a), .pos_col (col_a),
    .size_h (sh_a), .size_w (sw_a),
    .at_edge (ed_a), .commit_valid (cv_a)
  );

  multi_paddle_ctrl #(
    .NUM_PADDLES (NP), .SAMPLE_DIV (SD), .VERT_ONLY (1)
  ) u_vert (
    .clk (clk), .reset (reset), .active (active),
    .new_frame (new_frame), .move (move),
    .pos_row (row_b), .pos_col (col_b),
    .size_h (sh_b), .size_w (sw_b),
    .at_edge (ed_b), .commit_valid (cv_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < NP; i++) begin
        mrow[v][i] = R / 2;
        mcol[v][i] = (C / (2 * NP)) * (2 * i + 1);
        mdv[v][i]  = 0;
        mdh[v][i]  = 0;
        med[v][i]  = 4'b0000;
      end
    mcv = 1'b0;
    mc  = 1;
  endtask

  function automatic int lim(input int x);
    if (x > MS) return MS;
    if (x < -MS) return -MS;
    return x;
  endfunction

  task automatic model_edge(input logic nf, input logic act,
                            input logic [7:0] mv);
    logic       tk;
    logic [3:0] b;
    int         r, c;
    tk  = (mc == SD) && !nf;
    mc  = (nf || mc == SD) ? 1 : mc + 1;
    mcv = nf;
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < NP; i++) begin
        b = mv[4*i +: 4];
        if (nf) begin
          med[v][i] = 4'b0000;
          r = mrow[v][i] + mdv[v][i];
          c = mcol[v][i] + mdh[v][i];
          if (r - H / 2 < 0) begin
            r = H / 2; med[v][i][3] = 1'b1;
          end else if (r + (H - 1) / 2 >= R) begin
            r = R - 1 - (H - 1) / 2; med[v][i][2] = 1'b1;
          end
          if (c - W / 2 < 0) begin
            c = W / 2; med[v][i][1] = 1'b1;
          end else if (c + (W - 1) / 2 >= C) begin
            c = C - 1 - (W - 1) / 2; med[v][i][0] = 1'b1;
          end
          mrow[v][i] = r;
          mcol[v][i] = c;
          mdv[v][i]  = 0;
          mdh[v][i]  = 0;
        end else if (tk && act) begin
          mdv[v][i] = lim(mdv[v][i] + int'(b[2] && !b[3])
                                    - int'(b[3] && !b[2]));
          if (v == 0)
            mdh[v][i] = lim(mdh[v][i] + int'(b[0] && !b[1])
                                      - int'(b[1] && !b[0]));
        end
      end
  endtask

  task automatic check_all(input string tag);
    logic [25:0] er, ec;
    logic [7:0]  ee;
    for (int v = 0; v < 2; v++) begin
      er = {mrow[v][1][12:0], mrow[v][0][12:0]};
      ec = {mcol[v][1][12:0], mcol[v][0][12:0]};
      ee = {med[v][1], med[v][0]};
      chk({tag, v == 0 ? "_free_row" : "_vert_row"},
          32'(v == 0 ? row_a : row_b), 32'(er));
      chk({tag, v == 0 ? "_free_col" : "_vert_col"},
          32'(v == 0 ? col_a : col_b), 32'(ec));
      chk({tag, v == 0 ? "_free_edge" : "_vert_edge"},
          32'(v == 0 ? ed_a : ed_b), 32'(ee));
      chk({tag, v == 0 ? "_free_cv" : "_vert_cv"},
          32'(v == 0 ? cv_a : cv_b), 32'(mcv));
    end
  endtask

  task automatic step(input logic [7:0] mv, input logic nf,
                      input logic act, input string tag);
    move      = mv;
    new_frame = nf;
    active    = act;
    @(posedge clk);
    #1;
    model_edge(nf, act, mv);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    move      = 8'h00;
    new_frame = 1'b0;
    active    = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    reset = 1'b0;
  endtask

  // Walk channel 0 row to target with whole frames of ticks.
  task automatic move_ch0_row(input int target);
    int k, n, guard;
    logic [7:0] d;
    guard = 0;
    while (mrow[0][0] != target && guard < 100) begin
      k = target - mrow[0][0];
      d = (k > 0) ? 8'h04 : 8'h08;
      n = (k > 0) ? k : -k;
      if (n > MS) n = MS;
      repeat (n * SD) step(d, 1'b0, 1'b1, "walk");
      step(8'h00, 1'b1, 1'b1, "walk_nf");
      guard++;
    end
    chk("walk_reached", 32'(mrow[0][0]), 32'(target));
  endtask

  initial begin
    reset     = 1'b1;
    move      = 8'h00;
    new_frame = 1'b0;
    active    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    chk("size_h", 32'(sh_a), 32'd50);
    chk("size_w", 32'(sw_b), 32'd20);
    reset = 1'b0;

    repeat (30)
      step(8'($urandom), $urandom_range(0, 7) == 0,
           1'b1, "warm");

    do_reset("midrst");
    chk("rst_row", 32'(row_a), 32'({13'd240, 13'd240}));
    chk("rst_col", 32'(col_a), 32'({13'd480, 13'd160}));
    step(8'h00, 1'b1, 1'b0, "idle_nf");
    chk("idle_cv", 32'(cv_a), 32'd1);
    step(8'h00, 1'b0, 1'b0, "idle_after");
    chk("idle_cv_drop", 32'(cv_a), 32'd0);

    repeat (3 * SD) step(8'h04, 1'b0, 1'b1, "down3");
    step(8'h00, 1'b1, 1'b1, "down3_nf");
    chk("down3_row", 32'(row_a[12:0]), 32'd243);
    chk("down3_ch1", 32'(row_a[25:13]), 32'd240);
    repeat (3 * SD) step(8'h0C, 1'b0, 1'b1, "ud");
    step(8'h00, 1'b1, 1'b1, "ud_nf");
    chk("ud_row", 32'(row_a[12:0]), 32'd243);

    do_reset("rst3");
    repeat (20 * SD) step(8'h04, 1'b0, 1'b1, "sat");
    step(8'h00, 1'b1, 1'b1, "sat_nf");
    chk("sat_row", 32'(row_a[12:0]), 32'd248);
    step(8'h00, 1'b1, 1'b1, "sat_nf2");
    chk("sat_row2", 32'(row_a[12:0]), 32'd248);

    move_ch0_row(27);
    repeat (5 * SD) step(8'h08, 1'b0, 1'b1, "top");
    step(8'h00, 1'b1, 1'b1, "top_nf");
    chk("top_row", 32'(row_a[12:0]), 32'd25);
    chk("top_flag", 32'(ed_a[3]), 32'd1);
    step(8'h00, 1'b1, 1'b1, "top_clr");
    chk("top_flag_clr", 32'(ed_a[3]), 32'd0);
    move_ch0_row(452);
    repeat (8 * SD) step(8'h04, 1'b0, 1'b1, "bot");
    step(8'h00, 1'b1, 1'b1, "bot_nf");
    chk("bot_row", 32'(row_a[12:0]), 32'd455);
    chk("bot_flag", 32'(ed_a[2]), 32'd1);

    do_reset("rst5");
    repeat (6 * SD) step(8'h20, 1'b0, 1'b1, "left");
    step(8'h00, 1'b1, 1'b1, "left_nf");
    chk("vert_col", 32'(col_b[25:13]), 32'd480);
    chk("vert_noleft", 32'(ed_b[5]), 32'd0);
    chk("free_col", 32'(col_a[25:13]), 32'd474);

    do_reset("rst6");
    repeat (SD - 1) step(8'h04, 1'b0, 1'b1, "coin");
    step(8'h04, 1'b1, 1'b1, "coin_nf");
    chk("coin_row", 32'(row_a[12:0]), 32'd240);
    repeat (SD - 1) step(8'h04, 1'b0, 1'b1, "rst_cnt");
    step(8'h00, 1'b1, 1'b1, "rst_cnt_nf");
    chk("cnt_restart", 32'(row_a[12:0]), 32'd240);
    repeat (SD) step(8'h04, 1'b0, 1'b1, "one");
    step(8'h00, 1'b1, 1'b1, "one_nf");
    chk("one_tick", 32'(row_a[12:0]), 32'd241);
    repeat (5 * SD) step(8'h04, 1'b0, 1'b0, "inact");
    step(8'h00, 1'b1, 1'b0, "inact_nf");
    chk("inact_row", 32'(row_a[12:0]), 32'd241);

    repeat (800)
      step(8'($urandom), $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
